conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter X_COUNT, 16, input samples per frame; X_COUNT >= F_COUNT.
REQ-002 Parameter F_COUNT, 8, filter taps; F_COUNT >= 1.
REQ-003 Parameter STRIDE, 1, window step in samples; STRIDE >= 1.
REQ-004 Parameter MAC_LAT, 2, cycles from read address to accumulate-enable (memory read plus multiplier register); MAC_LAT >= 1.
REQ-005 Derived: OP_COUNT = (X_COUNT-F_COUNT)/STRIDE+1; AX = $clog2(X_COUNT); AF = max(1,$clog2(F_COUNT)); AY = max(1,$clog2(OP_COUNT)).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 s_valid_x  in  1  input sample valid.
REQ-009 s_ready_x  out  1  controller accepts input samples.
REQ-010 wr_en_x  out  1  x-memory write strobe.
REQ-011 addr_x  out  AX  x-memory address, write or read.
REQ-012 addr_f  out  AF  filter ROM address.
REQ-013 en_acc  out  1  accumulator enable.
REQ-014 clear_acc  out  1  accumulator clear.
REQ-015 m_valid_y  out  1  output result valid.
REQ-016 m_ready_y  in  1  downstream accepts result.
REQ-017 y_idx  out  AY  index of the window currently held or computed.

Function
REQ-018 FSM states: LOAD, COMPUTE, DRAIN, OUTPUT.
REQ-019 LOAD: s_ready_x=1; wr_en_x=s_valid_x; addr_x=write pointer; each accepted sample increments the pointer.
REQ-020 LOAD to COMPUTE: on the cycle the write to address X_COUNT-1 is accepted; base=0, tap k=0, y_idx=0.
REQ-021 COMPUTE: lasts exactly F_COUNT cycles; addr_x=base+k, addr_f=k, k=0..F_COUNT-1, one read issued per cycle.
REQ-022 Issue flags pass through a MAC_LAT-deep shift register; en_acc is its output, so it is high for exactly F_COUNT consecutive cycles per window.
REQ-023 DRAIN: lasts exactly MAC_LAT cycles after the last issue; then OUTPUT.
REQ-024 Latency: if the last sample is accepted in cycle 0, m_valid_y rises in cycle F_COUNT+MAC_LAT+1 (11 at defaults).
REQ-025 OUTPUT: m_valid_y=1 and y_idx are held stable until m_ready_y=1; en_acc=0 throughout.
REQ-026 clear_acc = m_valid_y & m_ready_y, combinational, one pulse per handshake.
REQ-027 After a handshake with y_idx<OP_COUNT-1: base+=STRIDE, y_idx+=1, next state COMPUTE.
REQ-028 After a handshake with y_idx=OP_COUNT-1: next state LOAD, pointer=0.
REQ-029 s_valid_x outside LOAD is ignored (wr_en_x=0).
REQ-030 m_ready_y outside OUTPUT has no effect.
REQ-031 addr_f=0 outside COMPUTE; addr_x equals the write pointer in LOAD and 0 in DRAIN/OUTPUT.
REQ-032 Base address never exceeds X_COUNT-F_COUNT; no address wrap-around occurs.

Reset
REQ-033 While reset is high, asynchronously: state=LOAD; pointer, base, k, y_idx and the shift register are 0; s_ready_x, wr_en_x, en_acc, clear_acc and m_valid_y are 0.
REQ-034 In the first cycle after reset deasserts, s_ready_x=1.
REQ-035 A reset in any state, including mid-COMPUTE or with m_valid_y high, abandons the frame; no partial result is emitted.

Configuration
REQ-036 Macro CONV_SEQ_CTRL_STALL_CNT_EN.
REQ-037 When defined: adds output port stall_cnt (32 bits). It counts cycles with m_valid_y=1 and m_ready_y=0, saturates at 2^32-1, and is cleared only by reset.
REQ-038 When undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-039 Defaults, 16 back-to-back samples: s_ready_x=0 the cycle after the 16th; addr_x/addr_f sweep 0..7; en_acc high 8 cycles; m_valid_y 11 cycles after the last write; 9 results total, y_idx 0..8.
REQ-040 m_ready_y low 5 cycles at window 3: m_valid_y and y_idx=3 held, en_acc=0, single clear_acc on release; with the macro defined, stall_cnt=5.
REQ-041 STRIDE=2, X=16, F=8: 5 results; read bases 0,2,4,6,8; after the 5th handshake s_ready_x=1 next cycle.
REQ-042 s_valid_x toggling 1/0 during LOAD: exactly 16 writes at addresses 0..15; s_valid_x held high in COMPUTE/OUTPUT: no wr_en_x.
REQ-043 Reset asserted at COMPUTE k=4: all outputs 0 immediately; s_ready_x=1 after release; the next frame yields 9 correct results.
REQ-044 F_COUNT=X_COUNT=8, MAC_LAT=1: exactly one result; m_valid_y 10 cycles after the last write.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 1-D convolution engine: loads a frame of X_COUNT samples, then for each
// output window issues F_COUNT tap reads, waits out the MAC pipeline and hands off one result.
// Optional macro CONV_SEQ_CTRL_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cnt).
module conv_seq_ctrl #(
  parameter int X_COUNT = 16,
  parameter int F_COUNT = 8,
  parameter int STRIDE  = 1,
  parameter int MAC_LAT = 2,
  localparam int OP_COUNT = (X_COUNT - F_COUNT) / STRIDE + 1,
  localparam int AX = (X_COUNT > 1) ? $clog2(X_COUNT) : 1,
  localparam int AF = (F_COUNT > 1) ? $clog2(F_COUNT) : 1,
  localparam int AY = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          wr_en_x,
  output logic [AX-1:0] addr_x,
  output logic [AF-1:0] addr_f,
  output logic          en_acc,
  output logic          clear_acc,
  output logic          m_valid_y,
  input  logic          m_ready_y,
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
  output logic [AY-1:0] y_idx
`else
  output logic [AY-1:0] y_idx
`endif
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [AX-1:0] X_LAST     = AX'(X_COUNT - 1);
  localparam logic [AF-1:0] F_LAST     = AF'(F_COUNT - 1);
  localparam logic [AY-1:0] OP_LAST    = AY'(OP_COUNT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);
  localparam logic [AX-1:0] STRIDE_AX  = AX'(STRIDE);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [AX-1:0]      ptr_q, ptr_d;
  logic [AX-1:0]      base_q, base_d;
  logic [AF-1:0]      k_q, k_d;
  logic [AY-1:0]      y_q, y_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [MAC_LAT-1:0] sr_q, sr_d;
  logic               issue;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    k_d     = k_q;
    y_d     = y_q;
    drain_d = drain_q;
    issue   = (state_q == COMPUTE);

    // Read-issue flags age through the MAC pipeline; the oldest one enables the accumulator.
    sr_d[0] = issue;
    for (int i = 1; i < MAC_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end

    unique case (state_q)
      LOAD: begin
        if (s_valid_x) begin
          if (ptr_q == X_LAST) begin
            ptr_d   = '0;
            base_d  = '0;
            k_d     = '0;
            y_d     = '0;
            state_d = COMPUTE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (k_q == F_LAST) begin
          k_d     = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = OUTPUT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (m_ready_y) begin
          if (y_q == OP_LAST) begin
            ptr_d   = '0;
            base_d  = '0;
            y_d     = '0;
            state_d = LOAD;
          end else begin
            base_d  = base_q + STRIDE_AX;
            y_d     = y_q + 1'b1;
            k_d     = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      base_q  <= '0;
      k_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      k_q     <= k_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      sr_q    <= sr_d;
    end
  end

  // Ready is masked by reset so the upstream sees no acceptance while reset is held.
  assign s_ready_x = (state_q == LOAD) & ~reset;
  assign wr_en_x   = s_ready_x & s_valid_x;
  assign addr_x    = (state_q == LOAD)    ? ptr_q :
                     (state_q == COMPUTE) ? (base_q + AX'(k_q)) : '0;
  assign addr_f    = (state_q == COMPUTE) ? k_q : '0;
  assign en_acc    = sr_q[MAC_LAT-1];
  assign m_valid_y = (state_q == OUTPUT);
  assign clear_acc = m_valid_y & m_ready_y;
  assign y_idx     = y_q;

`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_y && !m_ready_y && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: three configurations (defaults, STRIDE=2, X=F=8 with
// MAC_LAT=1) share one stimulus path; the unselected instances are held in reset.
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_valid, m_ready;
  int   sel;
  int   n_run = 0;
  int   n_fail = 0;

  logic rst_a, rst_b, rst_c;
  assign rst_a = rst | (sel != 0);
  assign rst_b = rst | (sel != 1);
  assign rst_c = rst | (sel != 2);

  logic       a_srdy, a_wr, a_en, a_clr, a_mv;
  logic [3:0] a_ax;
  logic [2:0] a_af;
  logic [3:0] a_y;
  logic       b_srdy, b_wr, b_en, b_clr, b_mv;
  logic [3:0] b_ax;
  logic [2:0] b_af;
  logic [2:0] b_y;
  logic       c_srdy, c_wr, c_en, c_clr, c_mv;
  logic [2:0] c_ax;
  logic [2:0] c_af;
  logic [0:0] c_y;
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
  logic [31:0] a_stall, b_stall, c_stall;
`endif

  conv_seq_ctrl #(.X_COUNT(16), .F_COUNT(8), .STRIDE(1), .MAC_LAT(2)) dut_a (
    .clk(clk), .reset(rst_a), .s_valid_x(s_valid), .s_ready_x(a_srdy), .wr_en_x(a_wr),
    .addr_x(a_ax), .addr_f(a_af), .en_acc(a_en), .clear_acc(a_clr), .m_valid_y(a_mv),
    .m_ready_y(m_ready),
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
    .stall_cnt(a_stall),
`endif
    .y_idx(a_y));

  conv_seq_ctrl #(.X_COUNT(16), .F_COUNT(8), .STRIDE(2), .MAC_LAT(2)) dut_b (
    .clk(clk), .reset(rst_b), .s_valid_x(s_valid), .s_ready_x(b_srdy), .wr_en_x(b_wr),
    .addr_x(b_ax), .addr_f(b_af), .en_acc(b_en), .clear_acc(b_clr), .m_valid_y(b_mv),
    .m_ready_y(m_ready),
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
    .stall_cnt(b_stall),
`endif
    .y_idx(b_y));

  conv_seq_ctrl #(.X_COUNT(8), .F_COUNT(8), .STRIDE(1), .MAC_LAT(1)) dut_c (
    .clk(clk), .reset(rst_c), .s_valid_x(s_valid), .s_ready_x(c_srdy), .wr_en_x(c_wr),
    .addr_x(c_ax), .addr_f(c_af), .en_acc(c_en), .clear_acc(c_clr), .m_valid_y(c_mv),
    .m_ready_y(m_ready),
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
    .stall_cnt(c_stall),
`endif
    .y_idx(c_y));

  logic        o_srdy, o_wr, o_en, o_clr, o_mv;
  logic [31:0] o_ax, o_af, o_y, o_stall;

  always_comb begin
    o_stall = 32'd0;
    case (sel)
      1: begin
        o_srdy = b_srdy; o_wr = b_wr; o_en = b_en; o_clr = b_clr; o_mv = b_mv;
        o_ax = 32'(b_ax); o_af = 32'(b_af); o_y = 32'(b_y);
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
        o_stall = b_stall;
`endif
      end
      2: begin
        o_srdy = c_srdy; o_wr = c_wr; o_en = c_en; o_clr = c_clr; o_mv = c_mv;
        o_ax = 32'(c_ax); o_af = 32'(c_af); o_y = 32'(c_y);
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
        o_stall = c_stall;
`endif
      end
      default: begin
        o_srdy = a_srdy; o_wr = a_wr; o_en = a_en; o_clr = a_clr; o_mv = a_mv;
        o_ax = 32'(a_ax); o_af = 32'(a_af); o_y = 32'(a_y);
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
        o_stall = a_stall;
`endif
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %0d expected %0d", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n back-to-back samples; ends in the first COMPUTE cycle with s_valid still high.
  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      #1;
      check("ld_wr", 32'(o_wr), 32'd1);
      check("ld_addr", o_ax, 32'(i));
      tick();
    end
    #1;
    check("ld_done_rdy", 32'(o_srdy), 32'd0);
    check("ld_done_wr", 32'(o_wr), 32'd0);
  endtask

  // Entered in the first COMPUTE cycle of a window; leaves in the cycle after the handshake.
  task automatic do_window(input int base, input int y, input int stall, input int lat);
    int  en_cnt = 0;
    bit  seen = 0;
    s_valid = 1'b1;
    #1;
    for (int c = 1; c <= 30; c++) begin
      if (o_mv) begin
        check("latency", 32'(c), 32'(lat));
        check("y_idx", o_y, 32'(y));
        seen = 1;
        break;
      end
      if (c <= 8) begin
        check("rd_addr_x", o_ax, 32'(base + c - 1));
        check("rd_addr_f", o_af, 32'(c - 1));
      end else begin
        check("drain_addr_f", o_af, 32'd0);
      end
      check("no_wr", 32'(o_wr), 32'd0);
      en_cnt += int'(o_en);
      tick();
    end
    if (!seen) check("mv_timeout", 32'd0, 32'd1);
    check("en_cnt", 32'(en_cnt), 32'd8);
    for (int s = 0; s < stall; s++) begin
      check("stall_mv", 32'(o_mv), 32'd1);
      check("stall_y", o_y, 32'(y));
      check("stall_en", 32'(o_en), 32'd0);
      check("stall_clr", 32'(o_clr), 32'd0);
      check("stall_wr", 32'(o_wr), 32'd0);
      tick();
    end
`ifdef CONV_SEQ_CTRL_STALL_CNT_EN
    if (stall > 0) check("stall_cnt", o_stall, 32'(stall));
`endif
    m_ready = 1'b1;
    s_valid = 1'b0;
    #1;
    check("hs_clr", 32'(o_clr), 32'd1);
    check("hs_en", 32'(o_en), 32'd0);
    tick();
    m_ready = 1'b0;
    #1;
    check("post_clr", 32'(o_clr), 32'd0);
  endtask

  task automatic run_frame(input int nres, input int stride, input int lat,
                           input int stall_win, input int stall_len);
    for (int w = 0; w < nres; w++) begin
      do_window(w * stride, w, (w == stall_win) ? stall_len : 0, lat);
    end
    check("end_rdy", 32'(o_srdy), 32'd1);
    check("end_mv", 32'(o_mv), 32'd0);
    check("end_addr_x", o_ax, 32'd0);
  endtask

  initial begin
    int wcnt;
    sel = 0;
    rst = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    check("rst_srdy", 32'(o_srdy), 32'd0);
    check("rst_wr", 32'(o_wr), 32'd0);
    check("rst_mv", 32'(o_mv), 32'd0);
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_clr", 32'(o_clr), 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check("rel_srdy", 32'(o_srdy), 32'd1);
    check("rel_wr", 32'(o_wr), 32'd0);

    load_frame(16);
    run_frame(9, 1, 11, 3, 5);

    // Toggled s_valid: exactly 16 writes at consecutive addresses.
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = (i % 2 == 0);
      #1;
      if (o_wr) begin
        check("tg_addr", o_ax, 32'(wcnt));
        wcnt++;
      end
      tick();
      if (wcnt == 16) break;
    end
    check("tg_count", 32'(wcnt), 32'd16);
    check("tg_rdy", 32'(o_srdy), 32'd0);

    // Abandon the frame at tap 4.
    for (int i = 0; i < 4; i++) tick();
    check("mid_af", o_af, 32'd4);
    check("mid_en", 32'(o_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_srdy", 32'(o_srdy), 32'd0);
    check("arst_en", 32'(o_en), 32'd0);
    check("arst_mv", 32'(o_mv), 32'd0);
    check("arst_af", o_af, 32'd0);
    check("arst_ax", o_ax, 32'd0);
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check("rel2_srdy", 32'(o_srdy), 32'd1);
    load_frame(16);
    run_frame(9, 1, 11, -1, 0);

    // STRIDE = 2
    rst = 1'b1;
    sel = 1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check("b_rdy", 32'(o_srdy), 32'd1);
    load_frame(16);
    run_frame(5, 2, 11, -1, 0);

    // X = F = 8, MAC_LAT = 1
    rst = 1'b1;
    sel = 2;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check("c_rdy", 32'(o_srdy), 32'd1);
    load_frame(8);
    run_frame(1, 1, 10, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
